// File: rtl/banked_byte_memory_pkg.sv
`default_nettype none
// ============================================================================
// memory_pkg : shared constants and FSM encoding for banked_byte_memory
// Revision   : 1.0
// ============================================================================
package memory_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   localparam int DEF_WIDTH    = 8;
   localparam int DEF_DEPTH    = 4;
   localparam int DEF_SCAN_DIV = 50_000_000;

endpackage
`default_nettype wire

// File: rtl/banked_byte_memory_if.sv
`default_nettype none
// ============================================================================
// banked_byte_memory_if : switch/button inputs and LED-side outputs
// Revision              : 1.0
// ============================================================================
interface banked_byte_memory_if #(
   parameter int WIDTH = memory_pkg::DEF_WIDTH,
   parameter int DEPTH = memory_pkg::DEF_DEPTH
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] data;
   logic             store;
   logic [AW-1:0]    addr;
   logic             clear;
   logic             scan;
   logic [WIDTH-1:0] memory;
   logic [AW-1:0]    shown_addr;
   logic             busy;
   logic             wr_ack;

   modport master (
      output data, store, addr, clear, scan,
      input  memory, shown_addr, busy, wr_ack
   );

   modport slave (
      input  data, store, addr, clear, scan,
      output memory, shown_addr, busy, wr_ack
   );
endinterface
`default_nettype wire

// File: rtl/banked_byte_memory_rise_detect.sv
`default_nettype none
// ============================================================================
// rise_detect : one-cycle pulse on a 0->1 transition of a level input
// Revision    : 1.0
// ============================================================================
module rise_detect #(
   parameter logic INIT = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic sig_i,
   output logic rise_o
);
   logic sig_q;

   // INIT=1 suppresses a pulse for a level already high when reset releases
   always_ff @(posedge clk) begin
      if (reset) sig_q <= INIT;
      else       sig_q <= sig_i;
   end

   assign rise_o = sig_i & ~sig_q;
endmodule
`default_nettype wire

// File: rtl/banked_byte_memory.sv
`default_nettype none
// ============================================================================
// banked_byte_memory : register-file word store with edge-triggered writes,
//                      sequential bulk clear and auto-scan display
// Revision           : 1.0
// ============================================================================
module banked_byte_memory
   import memory_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int SCAN_DIV = DEF_SCAN_DIV
) (
   input  logic                clk,
   input  logic                reset,
   banked_byte_memory_if.slave bus
);
   localparam int             AW      = $clog2(DEPTH);
   localparam int             PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [AW-1:0]  c_LAST  = AW'(DEPTH - 1);
   localparam logic [AW:0]    c_DEPTH = (AW + 1)'(DEPTH);
   localparam logic [PW-1:0]  c_PTERM = PW'(SCAN_DIV - 1);

   state_t           state_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    clr_ptr_q;
   logic             busy_q;
   logic             wr_ack_q;
   logic [AW-1:0]    scan_idx_q, scan_idx_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic             store_rise;
   logic             addr_ok;
   logic             shown_ok;
   logic [AW-1:0]    shown_addr;

   rise_detect #(.INIT(1'b1)) u_store_rise (
      .clk    (clk),
      .reset  (reset),
      .sig_i  (bus.store),
      .rise_o (store_rise)
   );

   assign addr_ok = ({1'b0, bus.addr} < c_DEPTH);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         busy_q    <= 1'b0;
         wr_ack_q  <= 1'b0;
         clr_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ack_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // clear wins over a coincident store edge, which is dropped
               if (bus.clear) begin
                  state_q   <= ST_CLEAR;
                  busy_q    <= 1'b1;
                  clr_ptr_q <= '0;
               end else if (store_rise && addr_ok) begin
                  mem_q[bus.addr] <= bus.data;
                  wr_ack_q        <= 1'b1;
               end
            end
            ST_CLEAR: begin
               mem_q[clr_ptr_q] <= '0;
               if (clr_ptr_q == c_LAST) begin
                  state_q   <= ST_IDLE;
                  busy_q    <= 1'b0;
                  clr_ptr_q <= '0;
               end else begin
                  clr_ptr_q <= clr_ptr_q + 1'b1;
               end
            end
         endcase
      end
   end

   always_comb begin
      presc_d    = presc_q;
      scan_idx_d = scan_idx_q;
      if (!bus.scan) begin
         presc_d    = '0;
         scan_idx_d = '0;
      end else if (presc_q == c_PTERM) begin
         presc_d    = '0;
         scan_idx_d = (scan_idx_q == c_LAST) ? '0 : scan_idx_q + 1'b1;
      end else begin
         presc_d = presc_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q    <= '0;
         scan_idx_q <= '0;
      end else begin
         presc_q    <= presc_d;
         scan_idx_q <= scan_idx_d;
      end
   end

   assign shown_addr     = bus.scan ? scan_idx_q : bus.addr;
   assign shown_ok       = ({1'b0, shown_addr} < c_DEPTH);
   assign bus.memory     = shown_ok ? mem_q[shown_addr] : '0;
   assign bus.shown_addr = shown_addr;
   assign bus.busy       = busy_q;
   assign bus.wr_ack     = wr_ack_q;
endmodule
`default_nettype wire

// File: tb/tb_banked_byte_memory.sv
`default_nettype none
// ============================================================================
// tb_banked_byte_memory : directed and randomized checks against a word-level model
// Revision              : 1.0
// ============================================================================
module tb_banked_byte_memory;
   localparam int W  = 8;
   localparam int D  = 4;
   localparam int SD = 3;
   localparam int AW = $clog2(D);

   logic clk = 1'b0;
   logic reset;

   banked_byte_memory_if #(.WIDTH(W), .DEPTH(D)) bus ();

   banked_byte_memory #(.WIDTH(W), .DEPTH(D), .SCAN_DIV(SD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // word-level reference: clear is a countdown of words left to zero,
   // scan position is the number of scanning cycles divided by SCAN_DIV
   logic [W-1:0] m_mem [D];
   int           m_clr_left;
   int           m_scan_cyc;
   bit           m_ack;
   bit           m_prev;
   bit           m_valid = 1'b0;

   int            obs_acks;
   int            obs_busy_cnt;
   logic [AW-1:0] obs_shown;
   logic [W-1:0]  obs_mem;
   logic          obs_ack;
   logic          obs_busy;

   task automatic cycle(input bit r, input bit c, input bit s, input bit sc,
                        input logic [AW-1:0] a, input logic [W-1:0] d);
      int idx;
      bit rise;
      reset     = r;
      bus.clear = c;
      bus.store = s;
      bus.scan  = sc;
      bus.addr  = a;
      bus.data  = d;
      @(negedge clk);
      idx       = sc ? (m_scan_cyc / SD) % D : int'(a);
      obs_shown = bus.shown_addr;
      obs_mem   = bus.memory;
      obs_ack   = bus.wr_ack;
      obs_busy  = bus.busy;
      if (bus.wr_ack) obs_acks++;
      if (bus.busy)   obs_busy_cnt++;
      if (m_valid) begin
         chk("shown_addr", bus.shown_addr, idx);
         chk("memory", bus.memory, m_mem[idx]);
         chk("busy", bus.busy, m_clr_left > 0);
         chk("wr_ack", bus.wr_ack, m_ack);
      end
      @(posedge clk);
      if (r) begin
         foreach (m_mem[i]) m_mem[i] = '0;
         m_clr_left = 0;
         m_ack      = 1'b0;
         m_prev     = 1'b1;
         m_scan_cyc = 0;
         m_valid    = 1'b1;
      end else begin
         rise   = s && !m_prev;
         m_prev = s;
         m_ack  = 1'b0;
         if (m_clr_left > 0) begin
            m_mem[D - m_clr_left] = '0;
            m_clr_left--;
         end else if (c) begin
            m_clr_left = D;
         end else if (rise && int'(a) < D) begin
            m_mem[a] = d;
            m_ack    = 1'b1;
         end
         m_scan_cyc = sc ? m_scan_cyc + 1 : 0;
      end
      #1;
   endtask

   task automatic fill();
      for (int i = 0; i < D; i++) begin
         cycle(0, 0, 1, 0, AW'(i), W'((i + 1) * 8'h11));
         cycle(0, 0, 0, 0, AW'(i), '0);
      end
   endtask

   task automatic read_all_zero(input string tag);
      for (int i = 0; i < D; i++) begin
         cycle(0, 0, 0, 0, AW'(i), '0);
         chk(tag, obs_mem, '0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [AW-1:0] seq  [13];
      logic [W-1:0]  memv [13];
      int            exp_seq [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
      bit            sc_r;

      // store held high through reset release must not write
      repeat (3) cycle(1, 0, 1, 0, '0, '0);
      obs_acks = 0;
      repeat (3) cycle(0, 0, 1, 0, '0, 8'h77);
      chk("rst_store_acks", obs_acks, 0);
      chk("rst_store_mem", obs_mem, '0);
      cycle(0, 0, 0, 0, '0, '0);

      // single write and readback
      cycle(0, 0, 1, 0, 2'd2, 8'hA5);
      cycle(0, 0, 0, 0, 2'd2, '0);
      chk("wr_ack_pulse", obs_ack, 1);
      chk("read_a5", obs_mem, 8'hA5);
      cycle(0, 0, 0, 0, 2'd0, '0);
      chk("wr_ack_drop", obs_ack, 0);
      chk("read_addr0", obs_mem, 8'h00);

      // held button writes once with the data present at the edge
      obs_acks = 0;
      repeat (10) cycle(0, 0, 1, 0, 2'd1, 8'h3C);
      repeat (3)  cycle(0, 0, 1, 0, 2'd1, 8'hFF);
      cycle(0, 0, 0, 0, 2'd1, '0);
      chk("held_acks", obs_acks, 1);
      chk("held_mem", obs_mem, 8'h3C);

      // reset during the second clear cycle
      fill();
      cycle(0, 1, 0, 0, '0, '0);
      cycle(0, 0, 0, 0, '0, '0);
      chk("clr_busy_on", obs_busy, 1);
      cycle(1, 0, 0, 0, '0, '0);
      cycle(0, 0, 0, 0, '0, '0);
      chk("rst_clr_busy", obs_busy, 0);
      read_all_zero("rst_clr_mem");

      // clear coinciding with a store edge, plus a store edge while busy
      fill();
      obs_acks     = 0;
      obs_busy_cnt = 0;
      cycle(0, 1, 1, 0, 2'd3, 8'h99);
      cycle(0, 0, 0, 0, 2'd3, '0);
      cycle(0, 0, 1, 0, 2'd3, 8'h66);
      repeat (4) cycle(0, 0, 0, 0, 2'd3, '0);
      chk("clr_acks", obs_acks, 0);
      chk("clr_busy_len", obs_busy_cnt, D);
      read_all_zero("clr_mem");

      // scan sequence with a write to word 0 along the way
      for (int i = 0; i < 13; i++) begin
         cycle(0, 0, i == 4, 1, (i == 4) ? 2'd0 : 2'd3, 8'h5A);
         seq[i]  = obs_shown;
         memv[i] = obs_mem;
      end
      for (int i = 0; i < 13; i++) chk("scan_seq", seq[i], exp_seq[i]);
      chk("scan_pre_wr", memv[0], 8'h00);
      chk("scan_wr", memv[12], 8'h5A);

      // leaving scan shows addr at once; re-entering restarts at word 0
      cycle(0, 0, 0, 1, 2'd2, '0);
      cycle(0, 0, 0, 0, 2'd2, '0);
      chk("scan_exit", obs_shown, 2);
      cycle(0, 0, 0, 1, 2'd2, '0);
      chk("scan_restart", obs_shown, 0);
      repeat (3) cycle(0, 0, 0, 1, 2'd2, '0);
      chk("scan_restart_step", obs_shown, 1);

      // randomized traffic against the model
      sc_r = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 29) == 0) sc_r = ~sc_r;
         cycle($urandom_range(0, 59) == 0, $urandom_range(0, 24) == 0,
               $urandom_range(0, 2) == 0, sc_r,
               AW'($urandom_range(0, D - 1)), W'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
